// File: rtl/mold_tx_pkg.sv
// Shared constants and FSM encoding for the MoldUDP64 transmitter.
// Optional build macro: MOLD_TX_SEQ_AUTO_EN (internal sequence numbering).
package mold_tx_pkg;
  localparam int HDR_LEN = 20;
  localparam int SID_W   = 80;
  localparam int SEQ_W   = 64;
  localparam int LEN_PFX = 2;
  localparam int OUT_B   = 8;
  localparam int BUF_B   = 16;
  localparam int IN_B    = OUT_B + LEN_PFX;
  localparam int FILL_W  = $clog2(BUF_B + 1);
  localparam int N_W     = $clog2(IN_B + 1);

  typedef enum logic [2:0] {IDLE, H0, H1, H2, MSG, FLUSH} mold_state_e;
endpackage

// File: rtl/mold_tx_packer.sv
// 16-byte byte packer: appends in_n bytes at the current fill, drains drain_n from the head.
module mold_tx_packer
  import mold_tx_pkg::*;
(
  input  logic                   clk,
  input  logic                   nreset,
  input  logic [N_W-1:0]         in_n,
  input  logic [IN_B*8-1:0]      in_data,
  input  logic [N_W-1:0]         drain_n,
  output logic [FILL_W-1:0]      fill,
  output logic [OUT_B*8-1:0]     head
);
  logic [BUF_B-1:0][7:0] buf_q, buf_nxt, in_ext;
  logic [FILL_W-1:0]     base, j;

  always_comb begin
    in_ext = '0;
    in_ext[IN_B-1:0] = in_data;
    base    = fill - FILL_W'(drain_n);
    buf_nxt = buf_q >> (8 * drain_n);
    j       = '0;
    // j wraps to a large value below base, so one unsigned compare bounds both ends
    for (int i = 0; i < BUF_B; i++) begin
      j = FILL_W'(i) - base;
      if (j < FILL_W'(in_n)) buf_nxt[i] = in_ext[j[$clog2(BUF_B)-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      buf_q <= '0;
      fill  <= '0;
    end else begin
      buf_q <= buf_nxt;
      fill  <= base + FILL_W'(in_n);
    end
  end

  assign head = buf_q[OUT_B-1:0];
endmodule

// File: rtl/mold_tx.sv
// MoldUDP64 packet builder: header + length-prefixed messages onto a 64-bit AXI stream.
// Define MOLD_TX_SEQ_AUTO_EN to number packets from an internal sequence register.
module mold_tx
  import mold_tx_pkg::*;
#(
  parameter int AXI_DATA_W = 64,
  parameter int AXI_KEEP_W = 8,
  parameter int ML_W       = 16
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  pkt_v_i,
  input  logic [SID_W-1:0]      pkt_sid_i,
  input  logic [SEQ_W-1:0]      pkt_seq_i,
  input  logic [ML_W-1:0]       pkt_cnt_i,
  output logic                  pkt_ready_o,
  input  logic                  msg_v_i,
  input  logic                  msg_start_i,
  input  logic [ML_W-1:0]       msg_len_i,
  input  logic [AXI_KEEP_W-1:0] msg_mask_i,
  input  logic [AXI_DATA_W-1:0] msg_data_i,
  output logic                  msg_ready_o,
  output logic                  udp_axis_tvalid_o,
  output logic [AXI_KEEP_W-1:0] udp_axis_tkeep_o,
  output logic [AXI_DATA_W-1:0] udp_axis_tdata_o,
  output logic                  udp_axis_tlast_o,
  input  logic                  udp_axis_tready_i
);
  localparam int RW = FILL_W + 1;
  // A start beat adds up to IN_B bytes, so beats are only taken with that much room
  localparam logic [RW-1:0] RDY_MAX = RW'(BUF_B - IN_B);

  mold_state_e           state;
  logic                  pkt_ready_q, msg_ready_q;
  logic [SID_W-1:0]      sid_q;
  logic [SEQ_W-1:0]      seq_q;
  logic [ML_W-1:0]       cnt_q, msgs_left, rem_q, rem_nxt, pc;
  logic [HDR_LEN*8-1:0]  hdr;
  logic [FILL_W-1:0]     fill;
  logic [OUT_B*8-1:0]    head;
  logic [N_W-1:0]        in_n, drain_n, hdr_n;
  logic [IN_B*8-1:0]     in_data;
  logic [RW-1:0]         room, fill_nxt;
  logic                  tvalid, tlast, hs, hdr_go, msg_acc, msg_end, pkt_done;
`ifdef MOLD_TX_SEQ_AUTO_EN
  logic [SEQ_W-1:0]      seq_auto;
`endif

  mold_tx_packer u_packer (
    .clk     (clk),
    .nreset  (nreset),
    .in_n    (in_n),
    .in_data (in_data),
    .drain_n (drain_n),
    .fill    (fill),
    .head    (head)
  );

  assign hdr      = {sid_q, seq_q, cnt_q};
  assign tvalid   = (fill >= FILL_W'(OUT_B)) || (state == FLUSH && fill != '0);
  assign tlast    = state == FLUSH && fill != '0 && fill <= FILL_W'(OUT_B);
  assign hs       = tvalid && udp_axis_tready_i;
  assign drain_n  = !hs ? '0 : (fill >= FILL_W'(OUT_B)) ? N_W'(OUT_B) : N_W'(fill);
  assign room     = RW'(BUF_B) - RW'(fill) + RW'(drain_n);
  assign fill_nxt = RW'(fill) - RW'(drain_n) + RW'(in_n);
  assign pkt_done = state == FLUSH && ((hs && tlast) || fill == '0);

  always_comb begin
    pc = '0;
    for (int i = 0; i < AXI_KEEP_W; i++) pc = pc + ML_W'(msg_mask_i[i]);
  end

  assign msg_acc = msg_ready_q && msg_v_i;
  assign rem_nxt = (msg_start_i ? msg_len_i : rem_q) - pc;
  assign msg_end = msg_acc && rem_nxt == '0;

  always_comb begin
    in_data = '0;
    hdr_n   = '0;
    in_n    = '0;
    hdr_go  = 1'b0;
    case (state)
      H0: begin
        hdr_n = N_W'(8);
        for (int k = 0; k < 8; k++) in_data[8*k +: 8] = hdr[HDR_LEN*8-1-8*k -: 8];
      end
      H1: begin
        hdr_n = N_W'(8);
        for (int k = 0; k < 8; k++) in_data[8*k +: 8] = hdr[HDR_LEN*8-1-8*(k+8) -: 8];
      end
      H2: begin
        hdr_n = N_W'(4);
        for (int k = 0; k < 4; k++) in_data[8*k +: 8] = hdr[HDR_LEN*8-1-8*(k+16) -: 8];
      end
      MSG: begin
        if (msg_start_i) in_data = {msg_data_i, msg_len_i[7:0], msg_len_i[15:8]};
        else             in_data[AXI_DATA_W-1:0] = msg_data_i;
      end
      default: ;
    endcase
    // Header words wait for space so a stalled output never overflows the packer
    hdr_go = hdr_n != '0 && RW'(hdr_n) <= room;
    if (hdr_go)       in_n = hdr_n;
    else if (msg_acc) in_n = msg_start_i ? N_W'(pc) + N_W'(LEN_PFX) : N_W'(pc);
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state       <= IDLE;
      pkt_ready_q <= 1'b1;
      msg_ready_q <= 1'b0;
      sid_q       <= '0;
      seq_q       <= '0;
      cnt_q       <= '0;
      msgs_left   <= '0;
      rem_q       <= '0;
`ifdef MOLD_TX_SEQ_AUTO_EN
      seq_auto    <= SEQ_W'(1);
`endif
    end else begin
      case (state)
        IDLE: if (pkt_v_i && pkt_ready_q) begin
          state       <= H0;
          pkt_ready_q <= 1'b0;
          sid_q       <= pkt_sid_i;
          cnt_q       <= pkt_cnt_i;
          msgs_left   <= pkt_cnt_i;
`ifdef MOLD_TX_SEQ_AUTO_EN
          seq_q       <= seq_auto;
`else
          seq_q       <= pkt_seq_i;
`endif
        end
        H0: if (hdr_go) state <= H1;
        H1: if (hdr_go) state <= H2;
        H2: if (hdr_go) begin
          if (cnt_q != '0) begin
            state       <= MSG;
            msg_ready_q <= fill_nxt <= RDY_MAX;
          end else begin
            state <= FLUSH;
          end
        end
        MSG: begin
          if (msg_acc) rem_q <= rem_nxt;
          if (msg_end) msgs_left <= msgs_left - ML_W'(1);
          if (msg_end && msgs_left == ML_W'(1)) begin
            state       <= FLUSH;
            msg_ready_q <= 1'b0;
          end else begin
            msg_ready_q <= fill_nxt <= RDY_MAX;
          end
        end
        FLUSH: if (pkt_done) begin
          state       <= IDLE;
          pkt_ready_q <= 1'b1;
`ifdef MOLD_TX_SEQ_AUTO_EN
          seq_auto    <= seq_auto + SEQ_W'(cnt_q);
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    udp_axis_tkeep_o = '0;
    for (int i = 0; i < AXI_KEEP_W; i++) udp_axis_tkeep_o[i] = tvalid && (fill > FILL_W'(i));
  end

  assign pkt_ready_o       = pkt_ready_q;
  assign msg_ready_o       = msg_ready_q;
  assign udp_axis_tvalid_o = tvalid;
  assign udp_axis_tlast_o  = tlast;
  assign udp_axis_tdata_o  = tvalid ? head : '0;
endmodule
